systolic_tile_sched: RTL and testbench
======================================

SYSTOLIC_TILE_SCHED -- requirements
Module: systolic_tile_sched

Interface
REQ-001 SHALL have parameter INT_WIDTH, default 11: integer bits of the fixed-point word, sign included.
REQ-002 SHALL have parameter FRAC_WIDTH, default 5: fraction bits; W = INT_WIDTH+FRAC_WIDTH.
REQ-003 SHALL have parameter SYSTOLIC_SIZE, default 2: array dimension N; only 2 is supported.
REQ-004 SHALL have parameter MAX_K, default 16: maximum reduction steps per tile; KW = clog2(MAX_K)+1.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have ports cfg_val (input, 1), cfg_rdy (output, 1) and cfg_k (input, KW): tile-job handshake and step count.
REQ-008 SHALL have ports op_val (input, 1), op_rdy (output, 1), op_data (input, N*W: A column k, lane i at bits [i*W+:W]) and op_weight (input, N*W: B row k).
REQ-009 SHALL have ports mult_recv_msg (output, systolic_mult_recv_msg), mult_recv_val (output, 1) and mult_recv_rdy (input, 1): feed to the array.
REQ-010 SHALL have ports mult_send_msg (input, systolic_mult_send_msg), mult_send_val (input, 1) and mult_send_rdy (output, 1): results from the array.
REQ-011 SHALL have ports res_val (output, 1), res_rdy (input, 1), res_row (output, N*W) and res_last (output, 1): result stream.
REQ-012 SHALL have ports busy (output, 1: FSM not in IDLE) and cfg_err (output, 1: one-cycle pulse on a rejected job).

Function
REQ-013 SHALL implement FSM states IDLE, FEED, DRAIN and COLLECT.
REQ-014 In IDLE, SHALL assert cfg_rdy=1; on a cfg handshake with 1<=cfg_k<=MAX_K, SHALL latch k and enter FEED on the next cycle.
REQ-015 On a cfg handshake with cfg_k==0 or cfg_k>MAX_K, SHALL stay in IDLE, pulse cfg_err for 1 cycle and issue no array traffic.
REQ-016 In FEED, SHALL drive mult_recv_val=op_val and op_rdy=mult_recv_rdy, so one op beat equals exactly one array beat.
REQ-017 SHALL drive data_0/weight_0 combinationally from lane 0 of the current op beat.
REQ-018 SHALL drive data_1/weight_1 from a skew register holding lane 1 of the previous accepted beat, zero on the first beat of a job.
REQ-019 SHALL update the skew register only on a mult_recv handshake; stalls SHALL NOT shift it.
REQ-020 After k accepted op beats, SHALL enter DRAIN.
REQ-021 In DRAIN, SHALL issue N-1 flush beats with mult_recv_val=1, lane-0 operands zero, lane-1 operands from the skew register, and op_rdy=0.
REQ-022 SHALL set run=1 on every array beat and final_run=1 only on the last DRAIN beat.
REQ-023 After the final_run handshake, SHALL enter COLLECT and clear the skew register.
REQ-024 In COLLECT, SHALL drive mult_send_rdy=res_rdy and res_val=mult_send_val, with res_row={result_1,result_0}.
REQ-025 SHALL count N result handshakes in COLLECT, assert res_last on the Nth, and return to IDLE on the next cycle.
REQ-026 SHALL hold mult_send_rdy=0 outside COLLECT, and mult_recv_val=0 and op_rdy=0 outside FEED/DRAIN.
REQ-027 SHALL pass data through with no arithmetic; the step counter SHALL be KW bits and SHALL NOT wrap for k<=MAX_K.
REQ-028 SHALL add no bubble at state boundaries: the FEED->DRAIN beat may issue on the cycle after the last op handshake.
REQ-029 Steady-state FEED throughput SHALL be 1 beat per cycle when op_val=mult_recv_rdy=1.

Reset
REQ-030 On reset, SHALL force state=IDLE, zero the counters and skew register, and drive cfg_rdy=0, op_rdy=0, mult_recv_val=0, mult_send_rdy=0, res_val=0, res_last=0, busy=0 and cfg_err=0.
REQ-031 Reset mid-job SHALL abandon the job; cfg_rdy=1 SHALL appear on the first cycle after reset deasserts.

Configuration
REQ-032 With SYSTOLIC_SCHED_PERF_EN defined, SHALL add output perf_cycles (32 bits), cleared on cfg accept, incrementing every non-IDLE cycle and saturating at all-ones.
REQ-033 With SYSTOLIC_SCHED_PERF_EN undefined, SHALL omit the perf_cycles port and counter entirely.

Structure
REQ-034 The shared package systolic_msgs SHALL own systolic_mult_recv_msg, systolic_mult_send_msg and the FSM state enum.
REQ-035 The skew register SHALL be a separate sub-module, systolic_skew_line (width N*W, enable, clear).

Verification
REQ-036 The bench SHALL apply cfg_k=1 and op lane0 (0x0020,0x0020), lane1 (0x0040,0x0020), i.e. 1.0/1.0 and 2.0/1.0, and SHALL check 2 array beats, the second with final_run=1, data_1=0x0040 and data_0=0.
REQ-037 The bench SHALL apply cfg_k=3 with op_val=1 and mult_recv_rdy=1 always, and SHALL check exactly 4 array beats in 4 consecutive cycles with final_run only on the 4th.
REQ-038 The bench SHALL hold mult_recv_rdy=0 for 3 cycles mid-FEED, and SHALL check that op_rdy=0, the skew register is unchanged and no beat is lost.
REQ-039 The bench SHALL apply cfg_k=0 and cfg_k=MAX_K+1, and SHALL check a cfg_err pulse, busy=0 and no mult_recv_val.
REQ-040 The bench SHALL toggle res_rdy 0/1 in COLLECT, and SHALL check 2 result handshakes, res_last on the 2nd and cfg_rdy=1 on the next cycle.
REQ-041 The bench SHALL assert reset during DRAIN, and SHALL check all outputs at reset values next cycle and a following cfg_k=2 job completes normally.

Source files
------------

// File: rtl/systolic_msgs.sv
// Message formats and scheduler state shared by the systolic tile scheduler and the array.
// Operand and result words are fixed at 16 bits (11 integer + 5 fraction).
package systolic_msgs;

    localparam int MSG_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FEED    = 2'd1,
        DRAIN   = 2'd2,
        COLLECT = 2'd3
    } sched_state_e;

    // One beat into the array: lane-0 and lane-1 operands plus run control.
    typedef struct packed {
        logic             run;
        logic             final_run;
        logic [MSG_W-1:0] data_0;
        logic [MSG_W-1:0] data_1;
        logic [MSG_W-1:0] weight_0;
        logic [MSG_W-1:0] weight_1;
    } systolic_mult_recv_msg;

    typedef struct packed {
        logic [MSG_W-1:0] result_0;
        logic [MSG_W-1:0] result_1;
    } systolic_mult_send_msg;

endpackage

// File: rtl/systolic_skew_line.sv
// One-stage skew register: delays lane-1 operands by one accepted array beat.
// Clear has priority over enable so a new job always starts from zero.
module systolic_skew_line #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: non-blocking assignment so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/systolic_tile_sched.sv
// Tile scheduler for a 2x2 systolic array: feeds skewed A/B operands, drains, then streams results.
// Define SYSTOLIC_SCHED_PERF_EN to add the perf_cycles (busy-cycle) counter output.
module systolic_tile_sched
    import systolic_msgs::*;
#(
    parameter int  INT_WIDTH     = 11,
    parameter int  FRAC_WIDTH    = 5,
    parameter int  SYSTOLIC_SIZE = 2,
    parameter int  MAX_K         = 16,
    localparam int W             = INT_WIDTH + FRAC_WIDTH,
    localparam int N             = SYSTOLIC_SIZE,
    localparam int KW            = $clog2(MAX_K) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_val,
    output logic                  cfg_rdy,
    input  logic [KW-1:0]         cfg_k,
    input  logic                  op_val,
    output logic                  op_rdy,
    input  logic [N*W-1:0]        op_data,
    input  logic [N*W-1:0]        op_weight,
    output systolic_mult_recv_msg mult_recv_msg,
    output logic                  mult_recv_val,
    input  logic                  mult_recv_rdy,
    input  systolic_mult_send_msg mult_send_msg,
    input  logic                  mult_send_val,
    output logic                  mult_send_rdy,
    output logic                  res_val,
    input  logic                  res_rdy,
    output logic [N*W-1:0]        res_row,
    output logic                  res_last,
    output logic                  busy,
    output logic                  cfg_err
`ifdef SYSTOLIC_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_cycles
`endif
);

    localparam logic [KW-1:0] MAX_K_V = KW'(MAX_K);

    sched_state_e   state;
    logic [KW-1:0]  k_reg;
    logic [KW-1:0]  step_cnt;
    logic [N*W-1:0] skew_q;
    logic           cfg_fire;
    logic           cfg_ok;
    logic           recv_fire;
    logic           send_fire;
    logic           skew_en;
    logic           skew_clr;

    assign cfg_fire  = cfg_val && cfg_rdy;
    assign cfg_ok    = (cfg_k != '0) && (cfg_k <= MAX_K_V);
    assign recv_fire = mult_recv_val && mult_recv_rdy;
    assign send_fire = res_val && res_rdy;
    assign res_row   = {mult_send_msg.result_1, mult_send_msg.result_0};

    // Skew holds {weight lane 1, data lane 1}; cleared at job start and once the array is flushed.
    assign skew_en  = (state == FEED) && recv_fire;
    assign skew_clr = (cfg_fire && cfg_ok) || ((state == DRAIN) && recv_fire && mult_recv_msg.final_run);

    systolic_skew_line #(
        .WIDTH (N*W)
    ) u_skew (
        .clk   (clk),
        .reset (reset),
        .en    (skew_en),
        .clr   (skew_clr),
        .d     ({op_weight[W +: W], op_data[W +: W]}),
        .q     (skew_q)
    );

    // Handshake outputs are decoded from state, so cfg_rdy is up on the first cycle out of reset.
    always_comb begin
        cfg_rdy       = 1'b0;
        op_rdy        = 1'b0;
        mult_recv_val = 1'b0;
        mult_recv_msg = '0;
        mult_send_rdy = 1'b0;
        res_val       = 1'b0;
        res_last      = 1'b0;
        busy          = 1'b0;
        if (!reset) begin
            busy = (state != IDLE);
            case (state)
                IDLE: cfg_rdy = 1'b1;
                FEED: begin
                    mult_recv_val          = op_val;
                    op_rdy                 = mult_recv_rdy;
                    mult_recv_msg.run      = 1'b1;
                    mult_recv_msg.data_0   = op_data[W-1:0];
                    mult_recv_msg.weight_0 = op_weight[W-1:0];
                    mult_recv_msg.data_1   = skew_q[W-1:0];
                    mult_recv_msg.weight_1 = skew_q[N*W-1:W];
                end
                DRAIN: begin
                    mult_recv_val           = 1'b1;
                    mult_recv_msg.run       = 1'b1;
                    mult_recv_msg.final_run = (step_cnt == KW'(N-2));
                    mult_recv_msg.data_1    = skew_q[W-1:0];
                    mult_recv_msg.weight_1  = skew_q[N*W-1:W];
                end
                COLLECT: begin
                    mult_send_rdy = res_rdy;
                    res_val       = mult_send_val;
                    res_last      = mult_send_val && (step_cnt == KW'(N-1));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            k_reg    <= '0;
            step_cnt <= '0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_fire) begin
                        if (cfg_ok) begin
                            k_reg    <= cfg_k;
                            step_cnt <= '0;
                            state    <= FEED;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (recv_fire) begin
                        if (step_cnt == k_reg - KW'(1)) begin
                            step_cnt <= '0;
                            state    <= DRAIN;
                        end else begin
                            step_cnt <= step_cnt + KW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (recv_fire) begin
                        if (mult_recv_msg.final_run) begin
                            step_cnt <= '0;
                            state    <= COLLECT;
                        end else begin
                            step_cnt <= step_cnt + KW'(1);
                        end
                    end
                end
                COLLECT: begin
                    if (send_fire) begin
                        if (res_last) begin
                            step_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            step_cnt <= step_cnt + KW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SYSTOLIC_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= '0;
        end else if (cfg_fire && cfg_ok) begin
            perf_cycles <= '0;
        end else if ((state != IDLE) && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Directed bench for systolic_tile_sched: a job-level model predicts every array beat,
// a negedge monitor compares each handshaken beat, and literal checks pin the model.
module tb_systolic_tile_sched;
    import systolic_msgs::*;

    localparam int MAX_K = 16;
    localparam int KW    = $clog2(MAX_K) + 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cfg_val;
    logic                  cfg_rdy;
    logic [KW-1:0]         cfg_k;
    logic                  op_val;
    logic                  op_rdy;
    logic [31:0]           op_data;
    logic [31:0]           op_weight;
    systolic_mult_recv_msg mult_recv_msg;
    logic                  mult_recv_val;
    logic                  mult_recv_rdy;
    systolic_mult_send_msg mult_send_msg;
    logic                  mult_send_val;
    logic                  mult_send_rdy;
    logic                  res_val;
    logic                  res_rdy;
    logic [31:0]           res_row;
    logic                  res_last;
    logic                  busy;
    logic                  cfg_err;
`ifdef SYSTOLIC_SCHED_PERF_EN
    logic [31:0]           perf_cycles;
`endif

    systolic_tile_sched dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_val       (cfg_val),
        .cfg_rdy       (cfg_rdy),
        .cfg_k         (cfg_k),
        .op_val        (op_val),
        .op_rdy        (op_rdy),
        .op_data       (op_data),
        .op_weight     (op_weight),
        .mult_recv_msg (mult_recv_msg),
        .mult_recv_val (mult_recv_val),
        .mult_recv_rdy (mult_recv_rdy),
        .mult_send_msg (mult_send_msg),
        .mult_send_val (mult_send_val),
        .mult_send_rdy (mult_send_rdy),
        .res_val       (res_val),
        .res_rdy       (res_rdy),
        .res_row       (res_row),
        .res_last      (res_last),
        .busy          (busy),
        .cfg_err       (cfg_err)
`ifdef SYSTOLIC_SCHED_PERF_EN
        ,
        .perf_cycles   (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Operands of the current job, lane 0 and lane 1 of A (data) and B (weight).
    logic [15:0] ops_d0 [MAX_K];
    logic [15:0] ops_d1 [MAX_K];
    logic [15:0] ops_w0 [MAX_K];
    logic [15:0] ops_w1 [MAX_K];

    systolic_mult_recv_msg exp_q [$];
    systolic_mult_recv_msg cap [32];
    int                    cap_cyc [32];
    int                    beat_n = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a k-step job yields k+1 array beats; lane 0 is the current column, lane 1 the
    // previous one (zero first), and the last beat is a zero-lane-0 flush with final_run.
    task automatic build_job(input int k);
        systolic_mult_recv_msg m;
        exp_q.delete();
        beat_n = 0;
        if (k >= 1 && k <= MAX_K) begin
            for (int j = 0; j <= k; j++) begin
                m           = '0;
                m.run       = 1'b1;
                m.final_run = (j == k);
                m.data_0    = (j < k) ? ops_d0[j] : 16'h0;
                m.weight_0  = (j < k) ? ops_w0[j] : 16'h0;
                m.data_1    = (j > 0) ? ops_d1[j-1] : 16'h0;
                m.weight_1  = (j > 0) ? ops_w1[j-1] : 16'h0;
                exp_q.push_back(m);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mult_recv_val && mult_recv_rdy) begin
            if (exp_q.size() == 0) begin
                fails++;
                tests++;
                $display("FAIL unexpected_beat: got %0h expected no beat", mult_recv_msg);
            end else begin
                check("recv_beat", mult_recv_msg, exp_q.pop_front());
            end
            if (beat_n < 32) begin
                cap[beat_n]     = mult_recv_msg;
                cap_cyc[beat_n] = cycle;
            end
            beat_n++;
        end
    end

    task automatic fill_ops(input logic [15:0] base);
        for (int i = 0; i < MAX_K; i++) begin
            ops_d0[i] = base + 16'(i);
            ops_d1[i] = base + 16'h0100 + 16'(i);
            ops_w0[i] = base + 16'h0200 + 16'(i);
            ops_w1[i] = base + 16'h0300 + 16'(i);
        end
    endtask

    task automatic do_cfg(input int k);
        cfg_val = 1'b1;
        cfg_k   = KW'(k);
        @(negedge clk);
        check("cfg_rdy_idle", cfg_rdy, 1'b1);
        tick();
        cfg_val = 1'b0;
    endtask

    task automatic feed_job(input int k, input int stall_at, input int stall_len);
        logic [15:0] prev_d1;
        int          got;
        for (int i = 0; i < k; i++) begin
            op_val    = 1'b1;
            op_data   = {ops_d1[i], ops_d0[i]};
            op_weight = {ops_w1[i], ops_w0[i]};
            if (i == stall_at) begin
                prev_d1       = (i == 0) ? 16'h0 : ops_d1[i-1];
                mult_recv_rdy = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    check("stall_op_rdy", op_rdy, 1'b0);
                    check("stall_skew_held", mult_recv_msg.data_1, prev_d1);
                    tick();
                end
                mult_recv_rdy = 1'b1;
            end
            got = 0;
            for (int t = 0; t < 20 && got == 0; t++) begin
                @(negedge clk);
                got = int'(op_rdy);
                tick();
            end
            check("op_accepted", got, 1);
        end
        op_val = 1'b0;
    endtask

    task automatic collect(input int toggle, input logic [15:0] base);
        int          got;
        int          cyc;
        logic [15:0] e0;
        logic [15:0] e1;
        got           = 0;
        cyc           = 0;
        mult_send_val = 1'b1;
        while (got < 2 && cyc < 40) begin
            e0                     = base + 16'(2*got);
            e1                     = base + 16'(2*got + 1);
            mult_send_msg.result_0 = e0;
            mult_send_msg.result_1 = e1;
            res_rdy                = (toggle != 0) ? ((cyc % 2) == 1) : 1'b1;
            @(negedge clk);
            if (exp_q.size() != 0) check("res_val_before_collect", res_val, 1'b0);
            if (!res_rdy) check("send_rdy_follows_res_rdy", mult_send_rdy, 1'b0);
            if (res_val && res_rdy) begin
                check("res_row", res_row, {e1, e0});
                check("res_last", res_last, (got == 1));
                got++;
            end
            tick();
            cyc++;
        end
        mult_send_val = 1'b0;
        res_rdy       = 1'b0;
        check("result_count", got, 2);
        @(negedge clk);
        check("cfg_rdy_after_job", cfg_rdy, 1'b1);
        check("busy_after_job", busy, 1'b0);
        check("beats_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_rdy"}, cfg_rdy, 1'b0);
        check({tag, "_op_rdy"}, op_rdy, 1'b0);
        check({tag, "_recv_val"}, mult_recv_val, 1'b0);
        check({tag, "_send_rdy"}, mult_send_rdy, 1'b0);
        check({tag, "_res_val"}, res_val, 1'b0);
        check({tag, "_res_last"}, res_last, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_cfg_err"}, cfg_err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        cfg_val       = 1'b0;
        cfg_k         = '0;
        op_val        = 1'b0;
        op_data       = '0;
        op_weight     = '0;
        mult_recv_rdy = 1'b1;
        mult_send_msg = '0;
        mult_send_val = 1'b1;
        res_rdy       = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("por");
        mult_send_val = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("cfg_rdy_out_of_reset", cfg_rdy, 1'b1);
        tick();

        // k=1: A col (1.0, 2.0), B row (1.0, 1.0) -> two beats, skew shows 2.0 on the flush.
        fill_ops(16'h0000);
        ops_d0[0] = 16'h0020; ops_w0[0] = 16'h0020;
        ops_d1[0] = 16'h0040; ops_w1[0] = 16'h0020;
        build_job(1);
        do_cfg(1);
        feed_job(1, -1, 0);
        collect(0, 16'h1000);
        check("k1_beats", beat_n, 2);
        check("k1_b0_final", cap[0].final_run, 1'b0);
        check("k1_b0_data_0", cap[0].data_0, 16'h0020);
        check("k1_b0_data_1", cap[0].data_1, 16'h0000);
        check("k1_b1_final", cap[1].final_run, 1'b1);
        check("k1_b1_data_1", cap[1].data_1, 16'h0040);
        check("k1_b1_weight_1", cap[1].weight_1, 16'h0020);
        check("k1_b1_data_0", cap[1].data_0, 16'h0000);
        tick();

        // k=3 at full rate: four beats on four consecutive cycles.
        fill_ops(16'h0100);
        build_job(3);
        do_cfg(3);
        feed_job(3, -1, 0);
        collect(1, 16'h2000);
        check("k3_beats", beat_n, 4);
        check("k3_span", cap_cyc[3] - cap_cyc[0], 3);
        check("k3_b2_final", cap[2].final_run, 1'b0);
        check("k3_b3_final", cap[3].final_run, 1'b1);
        check("k3_b3_data_1", cap[3].data_1, 16'h0202);
        tick();

        // k=4 with a 3-cycle array stall in front of the third op beat.
        fill_ops(16'h0a00);
        build_job(4);
        do_cfg(4);
        feed_job(4, 2, 3);
        collect(1, 16'h3000);
        check("k4_beats", beat_n, 5);
        tick();

        // Rejected jobs: zero steps and one over the limit.
        for (int b = 0; b < 2; b++) begin
            int bad_k;
            bad_k = (b == 0) ? 0 : MAX_K + 1;
            build_job(bad_k);
            do_cfg(bad_k);
            @(negedge clk);
            check("bad_cfg_err", cfg_err, 1'b1);
            check("bad_busy", busy, 1'b0);
            check("bad_recv_val", mult_recv_val, 1'b0);
            check("bad_cfg_rdy", cfg_rdy, 1'b1);
            tick();
            @(negedge clk);
            check("bad_cfg_err_pulse", cfg_err, 1'b0);
            repeat (3) tick();
            check("bad_no_beats", beat_n, 0);
        end

        // Reset while the flush beat is pending, then a clean k=2 job.
        fill_ops(16'h0500);
        build_job(2);
        do_cfg(2);
        feed_job(2, -1, 0);
        mult_recv_rdy = 1'b0;
        reset         = 1'b1;
        tick();
        @(negedge clk);
        check_reset_outputs("mid");
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("cfg_rdy_after_mid_reset", cfg_rdy, 1'b1);
        check("busy_after_mid_reset", busy, 1'b0);
        check("mid_reset_beats", beat_n, 2);
        exp_q.delete();
        mult_recv_rdy = 1'b1;
        tick();
        fill_ops(16'h0700);
        build_job(2);
        do_cfg(2);
        feed_job(2, -1, 0);
        collect(1, 16'h4000);
        check("post_reset_beats", beat_n, 3);
        check("post_reset_b0_skew", cap[0].data_1, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
